// File: rtl/morse_pkg.sv
// Shared definitions for the Morse keypad front end: key codes, FSM states
// and the key-code-to-edit-event decoder.
package morse_pkg;

    localparam logic [3:0] KEY_DOT    = 4'h0;
    localparam logic [3:0] KEY_DASH   = 4'h1;
    localparam logic [3:0] KEY_BKSP   = 4'hD;
    localparam logic [3:0] KEY_COMMIT = 4'hE;
    localparam logic [3:0] KEY_CLEAR  = 4'hF;

    localparam int unsigned MORSE_MAX_LEN = 6;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        EV_NONE   = 3'd0,
        EV_DOT    = 3'd1,
        EV_DASH   = 3'd2,
        EV_BKSP   = 3'd3,
        EV_COMMIT = 3'd4,
        EV_CLEAR  = 3'd5
    } edit_e;

    // Unmapped codes decode to EV_NONE so they are dropped without an error.
    function automatic edit_e decode_key(input logic [3:0] code);
        edit_e ev;
        case (code)
            KEY_DOT:    ev = EV_DOT;
            KEY_DASH:   ev = EV_DASH;
            KEY_BKSP:   ev = EV_BKSP;
            KEY_COMMIT: ev = EV_COMMIT;
            KEY_CLEAR:  ev = EV_CLEAR;
            default:    ev = EV_NONE;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/pulse_sync.sv
// Two-flop synchronizer followed by a rising-edge detector; emits a one-cycle
// pulse per low-to-high transition of an asynchronous level.
module pulse_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flag_i,
    output logic pulse_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= flag_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/morse_key_collector.sv
// Turns debounced keypad presses into Morse edit events, builds a symbol buffer
// and hands committed code words downstream over a valid/ready handshake.
module morse_key_collector
    import morse_pkg::*;
#(
    parameter int unsigned MAX_LEN     = MORSE_MAX_LEN,
    parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         keyboard_val,
    input  logic               key_pressed_flag,
    output logic [MAX_LEN-1:0] buf_code,
    output logic [2:0]         buf_len,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MAX_LEN-1:0] out_code,
    output logic [2:0]         out_len,
    output logic               err
);

    localparam int unsigned CW      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] TMAX  = CW'(TIMEOUT_CYC - 1);
    localparam logic [2:0]    LEN_MAX = 3'(MAX_LEN);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] buf_code_q, buf_code_d;
    logic [2:0]         buf_len_q, buf_len_d;
    logic [MAX_LEN-1:0] out_code_q, out_code_d;
    logic [2:0]         out_len_q, out_len_d;
    logic [CW-1:0]      timer_q, timer_d;
    logic               err_q, err_d;

    logic               key_evt;
    edit_e              ev;
    logic               do_commit;

    pulse_sync u_flag_sync (
        .clk_i   (clk),
        .rst_ni  (rst),
        .flag_i  (key_pressed_flag),
        .pulse_o (key_evt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_COLLECT;
            buf_code_q <= '0;
            buf_len_q  <= '0;
            out_code_q <= '0;
            out_len_q  <= '0;
            timer_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_code_q <= buf_code_d;
            buf_len_q  <= buf_len_d;
            out_code_q <= out_code_d;
            out_len_q  <= out_len_d;
            timer_q    <= timer_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        buf_code_d = buf_code_q;
        buf_len_d  = buf_len_q;
        out_code_d = out_code_q;
        out_len_d  = out_len_q;
        timer_d    = timer_q;
        err_d      = 1'b0;
        do_commit  = 1'b0;
        ev         = key_evt ? decode_key(keyboard_val) : EV_NONE;

        case (state_q)
            ST_COLLECT: begin
                timer_d = (buf_len_q == '0) ? '0 : timer_q + CW'(1);
                if (ev != EV_NONE) begin
                    timer_d = '0;
                end
                // A real key event outranks the idle timeout in the same cycle.
                case (ev)
                    EV_DOT, EV_DASH: begin
                        if (buf_len_q == LEN_MAX) begin
                            err_d = 1'b1;
                        end else begin
                            buf_code_d = buf_code_q | (MAX_LEN'(ev == EV_DASH) << buf_len_q);
                            buf_len_d  = buf_len_q + 3'd1;
                        end
                    end
                    EV_BKSP: begin
                        if (buf_len_q != '0) begin
                            buf_code_d = buf_code_q & ~(MAX_LEN'(1) << (buf_len_q - 3'd1));
                            buf_len_d  = buf_len_q - 3'd1;
                        end
                    end
                    EV_CLEAR: begin
                        buf_code_d = '0;
                        buf_len_d  = '0;
                    end
                    EV_COMMIT: begin
                        if (buf_len_q != '0) begin
                            do_commit = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    default: begin
                        if ((TIMEOUT_CYC != 0) && (buf_len_q != '0) && (timer_q == TMAX)) begin
                            do_commit = 1'b1;
                        end
                    end
                endcase

                if (do_commit) begin
                    out_code_d = buf_code_q;
                    out_len_d  = buf_len_q;
                    buf_code_d = '0;
                    buf_len_d  = '0;
                    timer_d    = '0;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                timer_d = '0;
                if (ev != EV_NONE) begin
                    err_d = 1'b1;
                end
                if (out_ready) begin
                    state_d = ST_COLLECT;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    assign buf_code  = buf_code_q;
    assign buf_len   = buf_len_q;
    assign out_valid = (state_q == ST_HOLD);
    assign out_code  = out_code_q;
    assign out_len   = out_len_q;
    assign err       = err_q;

endmodule

// File: tb/tb_morse_key_collector.sv
// Directed bench: a long-timeout instance for edit/handshake behaviour and a
// 20-cycle-timeout instance for auto-commit, sharing the same stimulus.
module tb_morse_key_collector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] keyboard_val = 4'h0;
    logic       key_pressed_flag = 1'b0;
    logic       out_ready = 1'b0;

    logic [5:0] buf_code_a, out_code_a, buf_code_t, out_code_t;
    logic [2:0] buf_len_a, out_len_a, buf_len_t, out_len_t;
    logic       out_valid_a, err_a, out_valid_t, err_t;

    int n_checks = 0;
    int n_fail   = 0;
    int errs_a   = 0;

    always #5 clk = ~clk;

    morse_key_collector #(.MAX_LEN(6), .TIMEOUT_CYC(100_000_000)) dut_a (
        .clk(clk), .rst(rst), .keyboard_val(keyboard_val), .key_pressed_flag(key_pressed_flag),
        .buf_code(buf_code_a), .buf_len(buf_len_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_code(out_code_a), .out_len(out_len_a), .err(err_a)
    );

    morse_key_collector #(.MAX_LEN(6), .TIMEOUT_CYC(20)) dut_t (
        .clk(clk), .rst(rst), .keyboard_val(keyboard_val), .key_pressed_flag(key_pressed_flag),
        .buf_code(buf_code_t), .buf_len(buf_len_t), .out_valid(out_valid_t), .out_ready(out_ready),
        .out_code(out_code_t), .out_len(out_len_t), .err(err_t)
    );

    // Counts high cycles of err, so a stuck or doubled pulse shows up as extra.
    always @(posedge clk) begin
        if (err_a === 1'b1) errs_a <= errs_a + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] k, input int hold);
        @(negedge clk);
        keyboard_val     = k;
        key_pressed_flag = 1'b1;
        repeat (hold) @(negedge clk);
        key_pressed_flag = 1'b0;
        repeat (50) @(negedge clk);
    endtask

    typedef struct {
        logic [3:0] key;
        logic [2:0] len;
        logic [5:0] code;
        int         errs;
        logic       valid;
    } vec_t;

    vec_t vecs[18];

    task automatic run_vec(input int i);
        int e0;
        e0 = errs_a;
        press(vecs[i].key, 10);
        check($sformatf("v%0d_len", i),   32'(buf_len_a),   32'(vecs[i].len));
        check($sformatf("v%0d_code", i),  32'(buf_code_a),  32'(vecs[i].code));
        check($sformatf("v%0d_err", i),   32'(errs_a - e0), 32'(vecs[i].errs));
        check($sformatf("v%0d_valid", i), 32'(out_valid_a), 32'(vecs[i].valid));
    endtask

    initial begin
        int e0;
        int c;
        int first;

        vecs[0]  = '{4'h0, 3'd1, 6'b000000, 0, 1'b0};
        vecs[1]  = '{4'h1, 3'd2, 6'b000010, 0, 1'b0};
        vecs[2]  = '{4'h0, 3'd3, 6'b000010, 0, 1'b0};
        vecs[3]  = '{4'hE, 3'd0, 6'b000000, 0, 1'b1};
        vecs[4]  = '{4'h1, 3'd1, 6'b000001, 0, 1'b0};
        vecs[5]  = '{4'h1, 3'd2, 6'b000011, 0, 1'b0};
        vecs[6]  = '{4'h0, 3'd3, 6'b000011, 0, 1'b0};
        vecs[7]  = '{4'h1, 3'd4, 6'b001011, 0, 1'b0};
        vecs[8]  = '{4'h0, 3'd5, 6'b001011, 0, 1'b0};
        vecs[9]  = '{4'h1, 3'd6, 6'b101011, 0, 1'b0};
        vecs[10] = '{4'h0, 3'd6, 6'b101011, 1, 1'b0};
        vecs[11] = '{4'hD, 3'd5, 6'b001011, 0, 1'b0};
        vecs[12] = '{4'hF, 3'd0, 6'b000000, 0, 1'b0};
        vecs[13] = '{4'hE, 3'd0, 6'b000000, 1, 1'b0};
        vecs[14] = '{4'h5, 3'd0, 6'b000000, 0, 1'b0};
        vecs[15] = '{4'h0, 3'd1, 6'b000000, 0, 1'b0};
        vecs[16] = '{4'hD, 3'd0, 6'b000000, 0, 1'b0};
        vecs[17] = '{4'hD, 3'd0, 6'b000000, 0, 1'b0};

        // Reset held for 3 cycles.
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_buf_code",  32'(buf_code_a),  0);
        check("rst_buf_len",   32'(buf_len_a),   0);
        check("rst_out_valid", 32'(out_valid_a), 0);
        check("rst_out_code",  32'(out_code_a),  0);
        check("rst_out_len",   32'(out_len_a),   0);
        check("rst_err",       32'(err_a),       0);
        rst = 1'b1;
        e0 = errs_a;
        repeat (5) @(negedge clk);
        check("idle_err",   32'(errs_a - e0), 0);
        check("idle_valid", 32'(out_valid_a), 0);

        // Latency of the first press: buffer updates on the third edge after the flag rises.
        @(negedge clk);
        keyboard_val     = 4'h0;
        key_pressed_flag = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("lat_k1_len", 32'(buf_len_a), 0);
        @(negedge clk);
        check("lat_k2_len", 32'(buf_len_a), 1);
        repeat (7) @(negedge clk);
        key_pressed_flag = 1'b0;
        repeat (50) @(negedge clk);
        check("v0_len", 32'(buf_len_a), 32'(vecs[0].len));
        for (int i = 1; i < 4; i++) run_vec(i);
        check("commit_out_code", 32'(out_code_a), 32'h02);
        check("commit_out_len",  32'(out_len_a),  3);

        // Accept: out_ready must not change out_valid combinationally.
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("ready_no_comb", 32'(out_valid_a), 1);
        @(negedge clk);
        out_ready = 1'b0;
        check("accept_drop", 32'(out_valid_a), 0);

        for (int i = 4; i < 18; i++) run_vec(i);

        // Auto-commit with the 20-cycle instance.
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        keyboard_val     = 4'h1;
        key_pressed_flag = 1'b1;
        c     = 0;
        first = 0;
        while (c < 200 && first == 0) begin
            @(negedge clk);
            c++;
            if (c == 3) check("to_buf_len", 32'(buf_len_t), 1);
            if (c == 10) key_pressed_flag = 1'b0;
            if (out_valid_t === 1'b1) first = c;
        end
        check("to_latency",  32'(first),      23);
        check("to_out_code", 32'(out_code_t), 1);
        check("to_out_len",  32'(out_len_t),  1);
        check("to_buf_len0", 32'(buf_len_t),  0);
        check("long_to_idle", 32'(out_valid_a), 0);
        repeat (30) @(negedge clk);

        // HOLD behaviour on the long-timeout instance (buffer holds one dash).
        press(4'h1, 10);
        press(4'hE, 10);
        check("hold_valid", 32'(out_valid_a), 1);
        check("hold_code",  32'(out_code_a),  32'h03);
        check("hold_len",   32'(out_len_a),   2);
        e0 = errs_a;
        press(4'h0, 10);
        check("hold_err",      32'(errs_a - e0), 1);
        check("hold_code_kept", 32'(out_code_a), 32'h03);
        check("hold_len_kept",  32'(out_len_a),  2);
        check("hold_buf_len",   32'(buf_len_a),  0);
        e0 = errs_a;
        press(4'h0, 1000);
        check("hold_long_err", 32'(errs_a - e0), 1);
        check("hold_valid2",   32'(out_valid_a), 1);

        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("accept2_drop", 32'(out_valid_a), 0);
        e0 = errs_a;
        press(4'h1, 1000);
        check("long_press_len",  32'(buf_len_a),    1);
        check("long_press_code", 32'(buf_code_a),   1);
        check("long_press_err",  32'(errs_a - e0),  0);

        press(4'hE, 10);
        check("hold3_valid", 32'(out_valid_a), 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_hold_valid", 32'(out_valid_a), 0);
        check("rst_hold_code",  32'(out_code_a),  0);
        check("rst_hold_len",   32'(out_len_a),   0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
